// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 op codes, FSM
// state encoding and small helpers that classify an op by signedness,
// result half and divide/remainder flavour.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Divide-family ops all have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is signed for the same set except MULHSU.
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_high_half(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_unit_iter_core.sv
// One iteration of the shared multiply/divide datapath. The caller keeps a
// {hi, lo} register pair: for multiply hi is the partial product and lo the
// remaining multiplier bits; for divide hi is the partial remainder and lo
// the dividend being shifted out while quotient bits shift in.
module muldiv_unit_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] acc;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shift-add step for multiply, restoring compare/subtract step for divide.
  always_comb begin
    acc     = lo_i[0] ? ({1'b0, hi_i} + {1'b0, b_i}) : {1'b0, hi_i};
    shifted = {hi_i, lo_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    if (is_div) begin
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = shifted[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_o = acc[XLEN:1];
      lo_o = {acc[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake on
// both sides. Holds the FSM, iteration counter, operand sign handling and
// the divide special cases; one datapath step lives in muldiv_unit_iter_core.
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies with a
// single-cycle combinational multiplier (latency 1) instead of iterating.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   special_val_q, special_val_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, is_special;
  logic [XLEN-1:0]   special_val;
  logic [CNT_W-1:0]  start_cnt;
  logic [XLEN-1:0]   hi_step, lo_step;
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   div_sel, div_fix, fix_result;

  assign in_ready   = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

  muldiv_unit_iter_core #(.XLEN(XLEN)) u_iter (
    .is_div (op_is_div(op_q)),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .b_i    (b_q),
    .hi_o   (hi_step),
    .lo_o   (lo_step)
  );

  // Decode an incoming request: magnitudes, result sign, special cases, iteration count.
  always_comb begin
    a_neg      = op_a_signed(in_op) && in_a[XLEN-1];
    b_neg      = op_b_signed(in_op) && in_b[XLEN-1];
    a_mag      = a_neg ? -in_a : in_a;
    b_mag      = b_neg ? -in_b : in_b;
    div_zero   = op_is_div(in_op) && (in_b == '0);
    div_ovf    = ((in_op == MD_DIV) || (in_op == MD_REM)) && (in_a == MIN_VAL) && (in_b == '1);
    is_special = div_zero || div_ovf;
    if (div_zero) begin
      special_val = op_is_rem(in_op) ? in_a : '1;
    end else begin
      special_val = op_is_rem(in_op) ? '0 : MIN_VAL;
    end
`ifdef MULDIV_FAST_MUL_EN
    start_cnt = (is_special || !op_is_div(in_op)) ? '0 : CNT_W'(XLEN);
`else
    start_cnt = is_special ? '0 : CNT_W'(XLEN);
`endif
  end

  // Final sign fix-up and selection of the architectural result.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = {{XLEN{1'b0}}, lo_q} * {{XLEN{1'b0}}, b_q};
`else
    prod_mag = {hi_q, lo_q};
`endif
    prod_fix = neg_q ? -prod_mag : prod_mag;
    div_sel  = op_is_rem(op_q) ? hi_q : lo_q;
    div_fix  = neg_q ? -div_sel : div_sel;
    if (special_q) begin
      fix_result = special_val_q;
    end else if (op_is_div(op_q)) begin
      fix_result = div_fix;
    end else if (op_high_half(op_q)) begin
      fix_result = prod_fix[2*XLEN-1:XLEN];
    end else begin
      fix_result = prod_fix[XLEN-1:0];
    end
  end

  // FSM next state: iterate in BUSY, present in DONE, accept/drain/flush handling.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    b_d           = b_q;
    neg_d         = neg_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;

    case (state_q)
      ST_BUSY: begin
        if (cnt_q != '0) begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q - 1'b1;
        end else begin
          out_result_d = fix_result;
          out_valid_d  = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      op_d          = in_op;
      hi_d          = '0;
      lo_d          = a_mag;
      b_d           = b_mag;
      neg_d         = op_is_rem(in_op) ? a_neg : (a_neg ^ b_neg);
      special_d     = is_special;
      special_val_d = special_val;
      cnt_d         = start_cnt;
      state_d       = ST_BUSY;
    end

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      b_q           <= '0;
      neg_q         <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      b_q           <= b_d;
      neg_q         <= neg_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake,
// flush and reset behaviour on a 32-bit instance, randomized ops against an
// arithmetic reference model, and a 64-bit instance for wide divides.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, flush64;
  logic [2:0]  in_op64;
  logic [63:0] in_a64, in_b64, out_result64;

  int          vectors = 0;
  int          checks = 0;
  int          miscompares = 0;
  int          got_lat;
  int          waited;
  logic [63:0] got_res;
  logic [31:0] held;
  logic        seen_valid;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid64),
    .in_ready   (in_ready64),
    .in_op      (in_op64),
    .in_a       (in_a64),
    .in_b       (in_b64),
    .flush      (flush64),
    .out_valid  (out_valid64),
    .out_ready  (out_ready64),
    .out_result (out_result64)
  );

  // Reference results computed with plain wide arithmetic from the RISC-V M rules.
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0]; end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV:    begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      OP_DIVU:   begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      OP_REM:    begin
        if (b == 0) r = a;
        else if (ovf) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default:   begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = {64'h0, a} * {64'h0, b};
    case (op)
      OP_MUL:   return p[63:0];
      OP_MULHU: return p[127:64];
      OP_DIVU:  return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int xlen);
    if (op[2]) begin
      if (b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return xlen + 1;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return xlen + 1;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request on the 32-bit unit, wait for acceptance, then count edges to out_valid.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    vectors++;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    #1;
    while (in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    got_lat   = 0;
    while (out_valid !== 1'b1 && got_lat < 200) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_res = {32'h0, out_result};
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    apply_stimulus(op, a, b);
    check_output({tag, " result"}, got_res, {32'h0, ref32(op, a, b)});
    check_output({tag, " latency"}, 64'(got_lat), 64'(exp_latency(op, a, b, 32)));
    drain;
  endtask

  task automatic run_check64(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int lat;
    vectors++;
    in_valid64 = 1'b1;
    in_op64    = op;
    in_a64     = a;
    in_b64     = b;
    #1;
    check_output({tag, " in_ready"}, {63'h0, in_ready64}, 64'h1);
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 0;
    while (out_valid64 !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({tag, " result"}, out_result64, ref64(op, a, b));
`ifdef MULDIV_FAST_MUL_EN
    check_output({tag, " latency"}, 64'(lat), op[2] ? 64'd65 : 64'd1);
`else
    check_output({tag, " latency"}, 64'(lat), 64'd65);
`endif
    out_ready64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] w_a, w_b;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b0; flush64 = 1'b0;
    in_op64 = '0; in_a64 = '0; in_b64 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset in_ready", {63'h0, in_ready}, 64'h1);
    check_output("reset out_valid", {63'h0, out_valid}, 64'h0);
    check_output("reset out_result", {32'h0, out_result}, 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed multiplies and divides");
    run_check("MUL", OP_MUL, 32'd7, 32'hFFFF_FFFD);
    check_output("drain out_valid", {63'h0, out_valid}, 64'h0);
    run_check("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
    run_check("MULH", OP_MULH, 32'h8000_0000, 32'h8000_0000);
    run_check("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_check("REM", OP_REM, 32'hFFFF_FFF9, 32'd2);
    run_check("DIVU", OP_DIVU, 32'd100, 32'd7);
    run_check("REMU", OP_REMU, 32'd100, 32'd7);
    run_check("DIV by zero", OP_DIV, 32'h0000_1234, 32'd0);
    run_check("REMU by zero", OP_REMU, 32'h0000_1234, 32'd0);
    run_check("DIV overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("REM overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("[TB] backpressure and back-to-back accept");
    apply_stimulus(OP_DIVU, 32'd1000, 32'd7);
    held = got_res[31:0];
    check_output("stall first result", got_res, {32'h0, ref32(OP_DIVU, 32'd1000, 32'd7)});
    repeat (5) begin
      @(posedge clk); #1;
      check_output("stall out_valid", {63'h0, out_valid}, 64'h1);
      check_output("stall out_result", {32'h0, out_result}, {32'h0, held});
      check_output("stall in_ready", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    apply_stimulus(OP_REM, 32'hFFFF_FF9C, 32'd7);
    check_output("b2b no wait", 64'(waited), 64'd0);
    check_output("b2b result", got_res, {32'h0, ref32(OP_REM, 32'hFFFF_FF9C, 32'd7)});
    check_output("b2b latency", 64'(got_lat), 64'd33);
    drain;

    $display("[TB] flush mid-operation");
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd5000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd3; in_b = 32'd3;
    #1;
    check_output("flush in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_output("flush out_valid", {63'h0, out_valid}, 64'h0);
    check_output("flush idle in_ready", {63'h0, in_ready}, 64'h1);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    check_output("flush no result", {63'h0, seen_valid}, 64'h0);
    check_output("flush request dropped", {63'h0, in_ready}, 64'h1);
    run_check("after flush", OP_DIVU, 32'd77, 32'd5);

    $display("[TB] reset pulse mid-divide");
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'h7FFF_0000; in_b = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("rst out_valid", {63'h0, out_valid}, 64'h0);
    check_output("rst out_result", {32'h0, out_result}, 64'h0);
    check_output("rst in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    check_output("rst no partial result", {63'h0, seen_valid}, 64'h0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 20));
        2:       r_b = 32'hFFFF_FFFF;
        default: r_b = $urandom;
      endcase
      run_check($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b);
    end

    $display("[TB] 64-bit instance");
    run_check64("DIVU64", OP_DIVU, 64'h8000_0000_0000_0000, 64'd3);
    for (int i = 0; i < 4; i++) begin
      w_a = {$urandom, $urandom};
      w_b = (i == 1) ? 64'(($urandom_range(1, 1000))) : {$urandom, $urandom};
      case (i)
        0:       run_check64("MULHU64", OP_MULHU, w_a, w_b);
        1:       run_check64("REMU64", OP_REMU, w_a, w_b);
        2:       run_check64("MUL64", OP_MUL, w_a, w_b);
        default: run_check64("DIVU64 rand", OP_DIVU, w_a, w_b >> 20);
      endcase
    end

    $display("[TB] %0d comparisons made", checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
